// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, oversample
// ratio and the baud divider calculation.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  // Receiver FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

  // Sample-counter positions used by the bit decision logic
  localparam logic [3:0] S_SAMP_A = 4'd7;
  localparam logic [3:0] S_SAMP_B = 4'd8;
  localparam logic [3:0] S_DECIDE = 4'd9;
  localparam logic [3:0] S_LAST   = 4'(OVERSAMPLE - 1);

  // Rounded clocks per oversample tick: round(clk_hz / (baud * OVERSAMPLE))
  function automatic int calc_div(input longint clk_hz, input longint baud);
    longint den;
    den = baud * OVERSAMPLE;
    return int'((clk_hz + den / 2) / den);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: counts 0..DIV-1 and fires a tick on DIV-1.
// A synchronous clear restarts the count so tick phase follows the start edge.
module baud_tick_gen #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  // Next-count: restart on clear or wrap after the tick
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Divider counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and 2-of-3 majority bit decision.
// A good stop bit ends the frame at mid-stop so back-to-back frames work;
// a low stop bit reports a framing error and waits for the line to go idle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = calc_div(longint'(CLK_HZ), longint'(BAUD));

  logic       rx_meta_q, rx_sync_q;
  state_t     state_q, state_d;
  logic [3:0] s_q, s_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       samp_a_q, samp_a_d;
  logic       samp_b_q, samp_b_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       tick;
  logic       div_clear;
  logic       maj;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (div_clear),
    .tick    (tick)
  );

  // Two-flop synchronizer; line idles high, so both flops reset to 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Majority of the two stored samples and the live sample at the decide tick
  assign maj = (samp_a_q & samp_b_q) | (samp_a_q & rx_sync_q) | (samp_b_q & rx_sync_q);

  // Divider and sample counter are held cleared while idle, which also
  // clears them on the clock that leaves idle
  assign div_clear = (state_q == ST_IDLE);

  // Receiver FSM, sampling and shift register
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    samp_a_d    = samp_a_q;
    samp_b_d    = samp_b_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (tick) begin
      s_d = s_q + 4'd1;
      if (s_q == S_SAMP_A) samp_a_d = rx_sync_q;
      if (s_q == S_SAMP_B) samp_b_d = rx_sync_q;
    end

    case (state_q)
      ST_IDLE: begin
        s_d = 4'd0;
        if (!rx_sync_q) state_d = ST_START;
      end
      ST_START: begin
        if (tick && s_q == S_DECIDE && maj) begin
          state_d = ST_IDLE;
        end else if (tick && s_q == S_LAST) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick && s_q == S_DECIDE) begin
          shift_d = {maj, shift_q[7:1]};
        end
        if (tick && s_q == S_LAST) begin
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (tick && s_q == S_DECIDE) begin
          if (maj) begin
            data_d     = shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      s_q         <= 4'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      samp_a_q    <= 1'b0;
      samp_b_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      samp_a_q    <= samp_a_d;
      samp_b_q    <= samp_b_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected events
// go to a scoreboard queue and are matched when the receiver pulses.
module tb_uart_rx;

  localparam int BIT      = 864;
  localparam int BIT_FAST = 847;  // sender 2% fast
  localparam int BIT_SLOW = 881;  // sender 2% slow

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic       is_err;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;

  uart_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int bclk);
    rx = v;
    wait_clks(bclk);
  endtask

  // Drive one 8N1 frame and record what the receiver should report
  task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_val);
    ev_t e;
    if (stop_val) begin
      e.is_err = 1'b0;
      e.d      = b;
      last_good = b;
    end else begin
      e.is_err = 1'b1;
      e.d      = last_good;
    end
    exp_q.push_back(e);
    $display("send 0x%02h bit=%0d stop=%0b", b, bclk, stop_val);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bclk);
    drive_bit(stop_val, bclk);
  endtask

  // Bounded wait for the scoreboard to drain
  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2 * BIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    ev_t e;
    if (rx_valid || frame_err) begin
      check("no_overlap", {31'd0, rx_valid & frame_err}, 32'd0);
      check("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
        check("event_data", {24'd0, data}, {24'd0, e.d});
        $display("event %s data=0x%02h expected 0x%02h",
                 frame_err ? "frame_err" : "rx_valid", data, e.d);
      end
    end
    if (rx_valid) begin
      n_valid++;
      check("valid_width", {31'd0, prev_valid}, 32'd0);
    end
    if (frame_err) begin
      n_ferr++;
      check("ferr_width", {31'd0, prev_ferr}, 32'd0);
    end
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
  end

  initial begin
    int v0, f0;

    // Reset state
    wait_clks(5);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    wait_clks(2 * BIT);

    // Single byte
    send_frame(8'h77, BIT, 1'b1);
    wait_drain("drain_77");
    check("busy_after_77", {31'd0, busy}, 32'd0);
    check("data_77", {24'd0, data}, 32'h77);

    // Back-to-back frames
    v0 = n_valid;
    send_frame(8'h61, BIT, 1'b1);
    send_frame(8'h64, BIT, 1'b1);
    wait_drain("drain_61_64");
    check("b2b_count", n_valid - v0, 2);
    wait_clks(BIT);

    // Short low glitch must be rejected as a false start
    v0 = n_valid;
    f0 = n_ferr;
    drive_bit(1'b0, 200);
    rx = 1'b1;
    wait_clks(BIT);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_ferr", n_ferr - f0, 0);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Framing error then break, then a good byte
    f0 = n_ferr;
    send_frame(8'h20, BIT, 1'b0);
    wait_clks(2000);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_data", {24'd0, data}, 32'h64);
    rx = 1'b1;
    wait_clks(BIT);
    check("ferr_count", n_ferr - f0, 1);
    check("break_exit_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h0D, BIT, 1'b1);
    wait_drain("drain_0d");
    check("data_0d", {24'd0, data}, 32'h0D);
    wait_clks(BIT);

    // Reset in the middle of bit 4
    v0 = n_valid;
    f0 = n_ferr;
    $display("send aborted frame 0x5a");
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i), BIT);
    drive_bit(1'b1, BIT / 2);
    reset_n = 1'b0;
    rx = 1'b1;
    wait_clks(5);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data", {24'd0, data}, 32'h00);
    last_good = 8'h00;
    reset_n = 1'b1;
    wait_clks(2 * BIT);
    check("abort_valid", n_valid - v0, 0);
    check("abort_ferr", n_ferr - f0, 0);
    send_frame(8'h73, BIT, 1'b1);
    wait_drain("drain_73");
    check("data_73", {24'd0, data}, 32'h73);
    wait_clks(BIT);

    // Baud tolerance
    send_frame(8'h55, BIT_FAST, 1'b1);
    wait_drain("drain_55_fast");
    wait_clks(BIT);
    send_frame(8'h55, BIT_SLOW, 1'b1);
    wait_drain("drain_55_slow");
    check("data_55", {24'd0, data}, 32'h55);
    wait_clks(BIT);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
